// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank sharing one decoder.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 100000,
  parameter int BLANK_CYC  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  input  logic [4*NUM_DIGITS-1:0] upd_data,
  output logic                    upd_ready,
  input  logic [NUM_DIGITS-1:0]   en_mask,
  output logic [3:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shd;
  logic [NUM_DIGITS-1:0]   lzm;
  logic                    cnt_wrap;
  logic                    frame_end;
  logic                    blank_win;

`ifdef SEG_LZ_BLANK_EN
  // Digit i blanks when it and every more-significant nibble are zero; digit 0 always shows.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] w);
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero && (w[4*i +: 4] == 4'h0);
      lz_mask[i] = all_zero;
    end
  endfunction
`endif

  assign cnt_wrap  = (cnt == CNT_LAST);
  assign frame_end = cnt_wrap && (idx == IDX_LAST);
  assign blank_win = (32'(cnt) < 32'(BLANK_CYC));
  assign upd_ready  = frame_end;
  assign frame_tick = frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Shadow word only changes at a frame boundary so a frame never mixes old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd <= '1;
      lzm <= '0;
    end else if (upd_valid && frame_end) begin
      shd <= upd_data;
`ifdef SEG_LZ_BLANK_EN
      lzm <= lz_mask(upd_data);
`else
      lzm <= '0;
`endif
    end
  end

  // Disabled digits still own their slot; they just stay dark.
  always_comb begin
    digit_code = 4'hF;
    an         = '1;
    if (!blank_win) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IDX_W'(i)) begin
          if (en_mask[i] && !lzm[i]) digit_code = shd[4*i +: 4];
          if (en_mask[i]) an[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NUM_DIGITS=4, DIV=10, BLANK_CYC=2).
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int DV = 10;
  localparam int BC = 2;
  localparam int FRAME = ND * DV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          upd_valid = 1'b0;
  logic [15:0]   upd_data = 16'h0;
  logic          upd_ready;
  logic [ND-1:0] en_mask = 4'hF;
  logic [3:0]    digit_code;
  logic [ND-1:0] an;
  logic          frame_tick;

  int n_chk  = 0;
  int n_fail = 0;
  int pos    = 0;
  logic [15:0] sb[$];

  seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DV), .BLANK_CYC(BC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_valid (upd_valid),
    .upd_data  (upd_data),
    .upd_ready (upd_ready),
    .en_mask   (en_mask),
    .digit_code(digit_code),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t pos=%0d)", tag, got, exp, $time, pos);
    end
  endtask

  // Compare one cycle against the frame word at the scoreboard head, then advance.
  task automatic tick_cycle();
    logic [15:0] w;
    logic [3:0]  ea, ec, nib;
    logic        lzb;
    int          slot, c;
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
      w = 16'hFFFF;
    end else begin
      w = sb[0];
    end
    slot = pos / DV;
    c    = pos % DV;
    nib  = 4'((w >> (4 * slot)) & 16'hF);
    lzb  = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    if (slot >= 1 && (w >> (4 * slot)) == 16'h0) lzb = 1'b1;
`endif
    if (c < BC) begin
      ea = 4'hF;
      ec = 4'hF;
    end else begin
      ea = en_mask[slot] ? ~(4'b0001 << slot) : 4'hF;
      ec = (en_mask[slot] && !lzb) ? nib : 4'hF;
    end
    check("an", 32'(an), 32'(ea));
    check("digit_code", 32'(digit_code), 32'(ec));
    check("frame_tick", 32'(frame_tick), 32'(pos == FRAME - 1));
    check("upd_ready", 32'(upd_ready), 32'(pos == FRAME - 1));
    if (pos == FRAME - 1) begin
      if (upd_valid) sb.push_back(upd_data);
      if (sb.size() > 1) void'(sb.pop_front());
      pos = 0;
    end else begin
      pos++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_code"}, 32'(digit_code), 32'hF);
    check({tag, "_ready"}, 32'(upd_ready), 32'd0);
    check({tag, "_tick"}, 32'(frame_tick), 32'd0);
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.push_back(16'hFFFF);
    pos = 0;

    // Frame 0 blank; load 1234 at its end
    for (int i = 0; i < FRAME; i++) begin
      if (i == FRAME - 1) begin upd_valid = 1'b1; upd_data = 16'h1234; end
      tick_cycle();
    end
    upd_valid = 1'b0;
    upd_data  = 16'hEEEE;

    // Frame 1 shows 1234
    for (int i = 0; i < FRAME; i++) tick_cycle();

    // Frame 2 with digits 1 and 3 disabled
    en_mask = 4'b0101;
    for (int i = 0; i < FRAME; i++) tick_cycle();
    en_mask = 4'hF;

    // Frame 3: valid held from cycle 5, data changes at 20
    for (int i = 0; i < FRAME; i++) begin
      if (i == 5)  begin upd_valid = 1'b1; upd_data = 16'hABCD; end
      if (i == 20) upd_data = 16'h5555;
      tick_cycle();
    end

    // Frames 4..7: valid stays high, re-transfer each frame end
    for (int i = 0; i < FRAME; i++) tick_cycle();
    for (int i = 0; i < FRAME; i++) begin
      if (i == 10) upd_data = 16'h0070;
      tick_cycle();
    end
    for (int i = 0; i < FRAME; i++) begin
      if (i == 10) upd_data = 16'h0000;
      tick_cycle();
    end
    for (int i = 0; i < FRAME; i++) begin
      if (i == 10) upd_data = 16'h1234;
      if (i == 15) en_mask = 4'b1010;
      tick_cycle();
    end
    en_mask = 4'hF;

    // Frame 8 shows 1234; reset asserted mid slot 2
    upd_valid = 1'b0;
    for (int i = 0; i < 24; i++) tick_cycle();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    sb.delete();
    sb.push_back(16'hFFFF);
    pos = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Blank frames after release; stray data without valid is ignored
    for (int i = 0; i < FRAME; i++) begin
      if (i == 7) upd_data = 16'h9999;
      tick_cycle();
    end
    for (int i = 0; i < FRAME; i++) begin
      if (i == FRAME - 1) begin upd_valid = 1'b1; upd_data = 16'h8765; end
      tick_cycle();
    end
    upd_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) tick_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's common-anode 7-segment display bank. It shares a single external BCD-to-7-segment decoder across NUM_DIGITS digit positions. Each cycle it presents one 4-bit digit code to the decoder and drives the matching active-low anode. A requester loads a new display word through a valid/ready handshake that takes effect only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 8, digit positions scanned; legal 1..16.
DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); must be > BLANK_CYC.
BLANK_CYC, 4, cycles at start of each slot with all anodes off (anti-ghosting); legal 0..DIV-1.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
upd_valid  in  1  requester has new display word
upd_data  in  4*NUM_DIGITS  new word; nibble i = digit i, digit 0 = rightmost
upd_ready  out  1  controller accepts upd_data this cycle
en_mask  in  NUM_DIGITS  live per-digit enable; 0 keeps that anode off
digit_code  out  4  code to external decoder; 4'hF = blank (all segments off)
an  out  NUM_DIGITS  anode drive, active-low, one-hot-low or all ones
frame_tick  out  1  one-cycle pulse on last cycle of each frame

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low. All registers clear immediately on rst_n=0, independent of clk.
- State: prescaler cnt (width clog2(DIV)), slot index idx (width max(1,clog2(NUM_DIGITS))), shadow word shd (4*NUM_DIGITS), leading-zero mask lzm (NUM_DIGITS).
- Reset values: cnt=0, idx=0, shd=all 4'hF, lzm=0. Resulting outputs: an=all ones, digit_code=4'hF, upd_ready=0, frame_tick=0.
- Prescaler: cnt increments each cycle and wraps DIV-1 -> 0. On the wrap cycle, idx increments and wraps NUM_DIGITS-1 -> 0.
- Frame end: frame_end = (cnt==DIV-1) && (idx==NUM_DIGITS-1). frame_tick = frame_end. upd_ready = frame_end.
- Outputs are combinational decodes of registered state; no pipeline latency.
- Blank window: while cnt < BLANK_CYC, an = all ones and digit_code = 4'hF.
- Active window: otherwise, digit_code = shd nibble idx, forced to 4'hF if lzm[idx]=1 or en_mask[idx]=0. an[idx]=0 only when en_mask[idx]=1; all other bits are 1.
- Disabled digits still consume their slot, so the duty cycle of enabled digits is constant.
- Handshake: a transfer occurs when upd_valid && upd_ready. shd <= upd_data (and lzm updated) on that edge, so slot 0 of the next frame shows the new data.
- upd_valid without upd_ready is ignored; the requester holds valid and data until a frame end.
- upd_data is sampled only on the transfer cycle; changes at any other time have no effect.
- upd_valid may stay high across multiple frame ends; each frame end re-transfers the current upd_data.
- en_mask is not shadowed; it takes effect on the next cycle's outputs.
- Reset mid-frame: outputs go to reset values immediately; after release, scanning restarts at cnt=0, idx=0, blank display, until the first transfer.
- NUM_DIGITS=1: idx stays 0; frame_end occurs every DIV cycles.

Optional Feature:
Macro SEG_LZ_BLANK_EN.
- Defined: on each transfer, lzm[i] <= 1 iff every nibble j >= i of upd_data equals 4'h0, for i >= 1; lzm[0] is always 0. Leading zeros therefore display blank, and digit 0 always shows.
- Undefined: lzm stays 0 and all zero digits display as 0.

Test Plan:
(All scenarios use NUM_DIGITS=4, DIV=10, BLANK_CYC=2.)
1. Reset: rst_n=0 mid-cycle -> an=4'b1111, digit_code=F, upd_ready=0 asynchronously, with no clk edge. After release, first frame_tick at cycle 39.
2. Load 16'h1234 at the first frame end, en_mask=4'hF -> next frame slots 0..3 give code 4,3,2,1 with an 1110,1101,1011,0111 at cnt 2..9. Cnt 0..1 of each slot give an=1111, code F.
3. Hold upd_valid=1 with data 16'hABCD from cycle 5 -> upd_ready is 0 until cycle 39. Transfer occurs there. Data changed at cycle 20 to 16'h5555 -> 16'h5555 displayed, not ABCD.
4. en_mask=4'b0101 with shd=16'h1234 -> slots 1 and 3 give an=1111, code F. Slots 0 and 2 show 4 and 2. Frame length is unchanged at 40 cycles.
5. SEG_LZ_BLANK_EN defined, load 16'h0070 -> digits 3,2 blank (F), digit 1=7, digit 0=0. Load 16'h0000 -> only digit 0 shows 0. Macro undefined, 16'h0070 -> 0,0,7,0 all shown.
6. Assert rst_n=0 during slot 2 after loading 16'h1234 -> display blank after release until the next transfer. Scan restarts at slot 0 at cnt=0.
